// File: rtl/core_pkg.sv
// Shared front-end types: fetch queue entry layout and the canonical NOP
// used in place of instructions that must not execute.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic        misaligned;
    logic        done;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// In-order fetch queue: entries are allocated at request time, filled in
// allocation order as responses return, and popped from the head by decode.
module ifetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [31:0]              alloc_pc_i,
  input  logic                     fill_i,
  input  logic [31:0]              fill_instr_i,
  input  logic                     fill_fault_i,
  input  logic                     mark_i,
  input  logic [31:0]              mark_pc_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   entries_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [PW-1:0]  fill_q, fill_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push;

  // NOTE: every variable gets its default first, so no path can infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    push    = alloc_i || mark_i;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else begin
      if (push)              tail_d = tail_q + PW'(1);
      // A misalignment marker is born complete, so the fill pointer skips it.
      if (fill_i || mark_i)  fill_d = fill_q + PW'(1);
      if (pop_i)             head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop_i);
    end
  end

  // NOTE: sequential state uses <= only; combinational logic above uses =.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is not reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (alloc_i) begin
        entries_q[tail_q] <= '{pc: alloc_pc_i, instr: NOP_INSTR, fault: 1'b0,
                               misaligned: 1'b0, done: 1'b0};
      end else if (mark_i) begin
        entries_q[tail_q] <= '{pc: mark_pc_i, instr: NOP_INSTR, fault: 1'b0,
                               misaligned: 1'b1, done: 1'b1};
      end
      if (fill_i) begin
        entries_q[fill_q].instr <= fill_fault_i ? NOP_INSTR : fill_instr_i;
        entries_q[fill_q].fault <= fill_fault_i;
        entries_q[fill_q].done  <= 1'b1;
      end
    end
  end

  assign head_o  = entries_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch front end: owns the fetch PC, issues word requests, tracks in-flight
// and to-be-discarded responses, and feeds decode from an in-order queue.
module ifetch_buffer
  import core_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic        out_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   marker_pc_q, marker_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          halted_q, halted_d;
  logic          marker_pend_q, marker_pend_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  logic          issue, rsp_drop, rsp_fill, pop, mark, head_live;

  // Issue uses the pre-pop occupancy so out_ready never reaches req_valid.
  always_comb begin
    req_valid = !rst && !redirect_valid && !halted_q && (drop_q == '0)
                && (count < CW'(DEPTH));
    req_addr  = fetch_pc_q;
    issue     = req_valid && req_ready;
    rsp_drop  = rsp_valid && (drop_q != '0);
    rsp_fill  = rsp_valid && (drop_q == '0) && (outstanding_q != '0) && !redirect_valid;
    head_live = (count != '0) && head.done;
    pop       = head_live && out_ready && !redirect_valid;
    mark      = marker_pend_q && !redirect_valid;

    out_valid      = !rst && head_live;
    out_pc         = out_valid ? head.pc : 32'h0;
    out_instr      = out_valid ? head.instr : NOP_INSTR;
    out_fault      = out_valid && head.fault;
    out_misaligned = out_valid && head.misaligned;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    marker_pc_d   = marker_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    halted_d      = halted_q;
    marker_pend_d = 1'b0;
    if (redirect_valid) begin
      // A response landing this cycle belongs to the old stream either way.
      drop_d        = drop_q + outstanding_q
                      - CW'(rsp_valid && ((drop_q != '0) || (outstanding_q != '0)));
      outstanding_d = '0;
      fetch_pc_d    = redirect_pc;
      halted_d      = is_misaligned(redirect_pc);
      marker_pend_d = is_misaligned(redirect_pc);
      marker_pc_d   = redirect_pc;
    end else begin
      if (rsp_drop) drop_d     = drop_q - CW'(1);
      if (issue)    fetch_pc_d = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      marker_pc_q   <= 32'h0;
      outstanding_q <= '0;
      drop_q        <= '0;
      halted_q      <= 1'b0;
      marker_pend_q <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      marker_pc_q   <= marker_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halted_q      <= halted_d;
      marker_pend_q <= marker_pend_d;
    end
  end

  // The misalignment marker enters one cycle after the flush so the cycle
  // following any redirect always presents an empty output.
  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid),
    .alloc_i      (issue),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (rsp_fill),
    .fill_instr_i (rsp_data),
    .fill_fault_i (rsp_err),
    .mark_i       (mark),
    .mark_pc_i    (marker_pc_q),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count)
  );

  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid && (outstanding_q == '0) && (drop_q == '0)));

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: a transaction-level model of the fetch stream plus
// a latency-randomising memory, checked every cycle, with directed scenarios.
module tb_ifetch_buffer;
  import core_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NEVER    = 32'h7fff_ffff;

  logic        clk, rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic        out_fault, out_misaligned;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_fault(out_fault), .out_misaligned(out_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit fault; bit mis; int avail; int tag; } exp_t;
  typedef struct { logic [31:0] addr; int epoch; bit err; int due; int tag; } fly_t;
  typedef struct { logic [31:0] addr; int cyc; } hs_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit fault; bit mis; int cyc; } out_t;

  exp_t exp_q[$];
  fly_t fly_q[$];
  hs_t  hs_log[$];
  out_t out_log[$];

  int checks = 0, errors = 0;
  int cyc = 0, epoch = 0, next_tag = 0, rc = 0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_halted = 1'b0;
  int          lat_min = 1, lat_max = 1, gap_pct = 0, err_pct = 0;
  logic [31:0] fault_addr = 32'h1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] hs_addr(input int i);
    return (i < hs_log.size()) ? hs_log[i].addr : 32'hDEAD_BEEF;
  endfunction

  function automatic int hs_cyc(input int i);
    return (i < hs_log.size()) ? hs_log[i].cyc : -1000;
  endfunction

  function automatic out_t out_at(input int i);
    out_t none;
    none = '{pc: 32'hDEAD_BEEF, instr: 32'hDEAD_BEEF, fault: 1'b0, mis: 1'b0, cyc: -1000};
    return (i < out_log.size()) ? out_log[i] : none;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model
  // by what the coming edge will do.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit o_rdy);
    bit   exp_rv, exp_ov, rsp_go, err;
    int   stale;
    fly_t f;
    exp_t e;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    req_ready      = rq_rdy;
    out_ready      = o_rdy;
    rsp_go    = (fly_q.size() > 0) && (fly_q[0].due <= cyc) && ($urandom_range(99) >= gap_pct);
    rsp_valid = rsp_go;
    rsp_data  = rsp_go ? word_of(fly_q[0].addr) : $urandom;
    rsp_err   = rsp_go ? fly_q[0].err : 1'($urandom_range(1));
    #1;
    stale = 0;
    foreach (fly_q[i]) if (fly_q[i].epoch != epoch) stale++;
    exp_rv = !redir && !m_halted && (stale == 0) && (exp_q.size() < DEPTH);
    exp_ov = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    check("req_valid", req_valid, exp_rv);
    if (req_valid && exp_rv) check("req_addr", req_addr, m_pc);
    check("out_valid", out_valid, exp_ov);
    if (out_valid && exp_ov) begin
      check("out_pc", out_pc, exp_q[0].pc);
      check("out_instr", out_instr, exp_q[0].instr);
      check("out_fault", out_fault, exp_q[0].fault);
      check("out_misaligned", out_misaligned, exp_q[0].mis);
    end

    if (rsp_go) begin
      f = fly_q.pop_front();
      if (!redir && f.epoch == epoch)
        foreach (exp_q[i]) if (exp_q[i].tag == f.tag) exp_q[i].avail = cyc + 1;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      m_pc     = rpc;
      m_halted = (rpc[1:0] != 2'b00);
      if (m_halted)
        exp_q.push_back('{pc: rpc, instr: NOP_INSTR, fault: 1'b0, mis: 1'b1, avail: cyc + 2, tag: -1});
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        out_log.push_back('{pc: out_pc, instr: out_instr, fault: out_fault, mis: out_misaligned, cyc: cyc});
        e = exp_q.pop_front();
      end
      if (req_valid && req_ready) begin
        err = (req_addr == fault_addr) || ($urandom_range(99) < err_pct);
        hs_log.push_back('{addr: req_addr, cyc: cyc});
        fly_q.push_back('{addr: req_addr, epoch: epoch, err: err,
                          due: cyc + int'($urandom_range(lat_max, lat_min)), tag: next_tag});
        exp_q.push_back('{pc: m_pc, instr: err ? NOP_INSTR : word_of(m_pc), fault: err, mis: 1'b0,
                          avail: NEVER, tag: next_tag});
        next_tag++;
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Let every in-flight response return, then redirect to a clean start.
  task automatic start_at(input logic [31:0] addr);
    for (int i = 0; i < 64 && fly_q.size() > 0; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("quiesce", fly_q.size(), 0);
    cycle(1'b1, addr, 1'b0, 1'b1);
    rc = cyc - 1;
    hs_log.delete();
    out_log.delete();
  endtask

  initial begin
    logic [31:0] rpc;
    int          r;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, NOP_INSTR);
    check("rst_out_fault", out_fault, 0);
    check("rst_out_misaligned", out_misaligned, 0);
    rst = 1'b0;

    // Streaming with 1-cycle memory.
    repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s1_addr0", hs_addr(0), RESET_PC);
    check("s1_addr1", hs_addr(1), 32'h4);
    check("s1_addr2", hs_addr(2), 32'h8);
    check("s1_addr3", hs_addr(3), 32'hC);
    check("s1_out0", out_at(0).pc, 32'h0);
    check("s1_out1", out_at(1).pc, 32'h4);
    check("s1_first_latency", out_at(0).cyc - hs_cyc(0), 2);

    // Back-pressure fills the queue; first pop frees exactly one slot.
    start_at(32'h0);
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("s2_issued", hs_log.size(), 4);
    check("s2_last", hs_addr(3), 32'hC);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s2_next", hs_addr(4), 32'h10);
    check("s2_next_cyc", hs_cyc(4), out_at(0).cyc + 1);

    // Redirect with two responses in flight.
    start_at(32'h0);
    lat_min = 3; lat_max = 3;
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h100, 1'b1, 1'b1);
    rc = cyc - 1;
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s3_addr", hs_addr(2), 32'h100);
    check("s3_wait", hs_cyc(2) - rc, 3);
    check("s3_out", out_at(0).pc, 32'h100);

    // Redirect in the same cycle as a response.
    start_at(32'h0);
    lat_min = 2; lat_max = 2;
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b1);
    rc = cyc - 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s4_addr", hs_addr(1), 32'h300);
    check("s4_cyc", hs_cyc(1), rc + 1);
    check("s4_out", out_at(0).pc, 32'h300);

    // Misaligned redirect halts fetch until the next redirect.
    lat_min = 1; lat_max = 1;
    start_at(32'h102);
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s5_no_issue", hs_log.size(), 0);
    check("s5_outs", out_log.size(), 1);
    check("s5_pc", out_at(0).pc, 32'h102);
    check("s5_mis", out_at(0).mis, 1);
    check("s5_instr", out_at(0).instr, NOP_INSTR);
    cycle(1'b1, 32'h200, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s5_resume", hs_addr(0), 32'h200);

    // Access fault on 0x8.
    start_at(32'h0);
    fault_addr = 32'h8;
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s6_pc", out_at(2).pc, 32'h8);
    check("s6_fault", out_at(2).fault, 1);
    check("s6_instr", out_at(2).instr, NOP_INSTR);
    check("s6_next_pc", out_at(3).pc, 32'hC);
    check("s6_next_fault", out_at(3).fault, 0);
    check("s6_next_instr", out_at(3).instr, 32'h5EE1_0001);
    fault_addr = 32'h1;

    // PC wrap.
    start_at(32'hFFFF_FFF8);
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("s7_a0", hs_addr(0), 32'hFFFF_FFF8);
    check("s7_a1", hs_addr(1), 32'hFFFF_FFFC);
    check("s7_a2", hs_addr(2), 32'h0);
    check("s7_out2", out_at(2).pc, 32'h0);

    // Randomised traffic.
    lat_min = 1; lat_max = 5; gap_pct = 30; err_pct = 5;
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(9);
      if (r == 0)      rpc = ($urandom & ~32'h3) | 32'($urandom_range(3, 1));
      else if (r == 1) rpc = 32'hFFFF_FFF0;
      else             rpc = 32'($urandom_range(1023)) << 2;
      cycle($urandom_range(99) < 3, rpc, $urandom_range(99) < 70, $urandom_range(99) < 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
